// File: rtl/modmul_sm2.sv
// modmul_sm2: sequential radix-2 interleaved modular multiplier, z = a*b mod P.
// One bit of a is consumed per cycle, MSB first. Level handshake on start_mul.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   start_mul  level launch request, sampled only in IDLE
//   a_in/b_in  operands, caller keeps them below P
//   z_out      product, held from the finish pulse until the next launch
//   finish_mul one-cycle pulse, z_out valid in that cycle
//   busy       high from launch until the cycle after the finish pulse
module modmul_sm2 #(
  parameter int unsigned          DATA_LEN = 256,
  parameter logic [DATA_LEN-1:0]  P        = DATA_LEN'(256'hFFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF00000000FFFFFFFFFFFFFFFF),
  parameter int unsigned          CNT_LEN  = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_mul,
  input  logic [DATA_LEN-1:0] a_in,
  input  logic [DATA_LEN-1:0] b_in,
  output logic [DATA_LEN-1:0] z_out,
  output logic                finish_mul,
  output logic                busy
);

  localparam int unsigned EXT_LEN = DATA_LEN + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t              r_state;
  logic [DATA_LEN-1:0] r_a;
  logic [DATA_LEN-1:0] r_b;
  logic [DATA_LEN-1:0] r_r;
  logic [CNT_LEN-1:0]  r_cnt;
  logic [DATA_LEN-1:0] r_z;
  logic                r_finish;
  logic                r_busy;

  logic [EXT_LEN-1:0]  w_p_ext;
  logic [EXT_LEN-1:0]  w_t1_raw;
  logic [DATA_LEN-1:0] w_t1;
  logic [EXT_LEN-1:0]  w_t2_raw;
  logic [DATA_LEN-1:0] w_t2;

  // One interleaved step: R <- (2R + bit*B) mod P, each partial sum kept below 2P
  // so a single conditional subtract restores R < P.
  assign w_p_ext  = {1'b0, P};
  assign w_t1_raw = {r_r, 1'b0};
  assign w_t1     = (w_t1_raw >= w_p_ext) ? DATA_LEN'(w_t1_raw - w_p_ext)
                                          : DATA_LEN'(w_t1_raw);
  assign w_t2_raw = {1'b0, w_t1} + (r_a[DATA_LEN-1] ? {1'b0, r_b} : {EXT_LEN{1'b0}});
  assign w_t2     = (w_t2_raw >= w_p_ext) ? DATA_LEN'(w_t2_raw - w_p_ext)
                                          : DATA_LEN'(w_t2_raw);

  // Control FSM and datapath registers; A shifts left so its MSB is the current bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_r      <= '0;
      r_cnt    <= '0;
      r_z      <= '0;
      r_finish <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_mul) begin
            r_a     <= a_in;
            r_b     <= b_in;
            r_r     <= '0;
            r_cnt   <= CNT_LEN'(DATA_LEN - 1);
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_r <= w_t2;
          r_a <= r_a << 1;
          if (r_cnt == '0) begin
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - CNT_LEN'(1);
          end
        end
        S_DONE: begin
          r_z      <= r_r;
          r_finish <= 1'b1;
          r_state  <= S_HOLD;
        end
        S_HOLD: begin
          r_finish <= 1'b0;
          r_busy   <= 1'b0;
          // A request still held high must not relaunch.
          if (!start_mul) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign z_out      = r_z;
  assign finish_mul = r_finish;
  assign busy       = r_busy;

endmodule

// File: tb/tb_modmul_sm2.sv
// tb_modmul_sm2: self-checking bench for modmul_sm2.
// A default SM2 instance covers directed cases, handshake, reset and a short random run;
// a 16-bit instance (P = 65521) covers a long random run at low cycle cost.
// Expected values come from plain wide-integer (a*b) % P arithmetic.
module tb_modmul_sm2;

  localparam logic [255:0] P_SM2 = 256'hFFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF00000000FFFFFFFFFFFFFFFF;
  localparam logic [15:0]  P_S   = 16'd65521;
  localparam int           LAT_BIG   = 258;
  localparam int           LAT_SMALL = 18;
  localparam int           BOUND     = 400;

  logic         clk = 1'b0;
  logic         rst = 1'b0;

  logic         start_mul = 1'b0;
  logic [255:0] a_in = '0;
  logic [255:0] b_in = '0;
  logic [255:0] z_out;
  logic         finish_mul;
  logic         busy;

  logic         s_start = 1'b0;
  logic [15:0]  s_a = '0;
  logic [15:0]  s_b = '0;
  logic [15:0]  s_z;
  logic         s_finish;
  logic         s_busy;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  modmul_sm2 dut (
    .clk       (clk),
    .rst       (rst),
    .start_mul (start_mul),
    .a_in      (a_in),
    .b_in      (b_in),
    .z_out     (z_out),
    .finish_mul(finish_mul),
    .busy      (busy)
  );

  modmul_sm2 #(.DATA_LEN(16), .P(P_S), .CNT_LEN(5)) dut_s (
    .clk       (clk),
    .rst       (rst),
    .start_mul (s_start),
    .a_in      (s_a),
    .b_in      (s_b),
    .z_out     (s_z),
    .finish_mul(s_finish),
    .busy      (s_busy)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] ref_mulmod(input logic [255:0] a, input logic [255:0] b,
                                              input logic [255:0] m);
    logic [511:0] prod;
    prod = {256'b0, a} * {256'b0, b};
    return 256'(prod % {256'b0, m});
  endfunction

  function automatic logic [255:0] ref_powmod(input logic [255:0] base, input logic [255:0] e,
                                              input logic [255:0] m);
    logic [255:0] r;
    r = 256'd1;
    for (int i = 255; i >= 0; i--) begin
      r = ref_mulmod(r, r, m);
      if (e[i]) r = ref_mulmod(r, base, m);
    end
    return r;
  endfunction

  function automatic logic [255:0] rand_below_p();
    logic [255:0] x;
    do begin
      for (int i = 0; i < 8; i++) x[i*32 +: 32] = $urandom;
    end while (x >= P_SM2);
    return x;
  endfunction

  // Launch one big multiply and wait (bounded) for the finish pulse; inputs are
  // scrambled right after the launch edge, optionally start is dropped mid-run.
  task automatic mul_big(input logic [255:0] a, input logic [255:0] b, input bit drop_mid,
                         output logic [255:0] z, output int lat);
    @(negedge clk);
    a_in = a;
    b_in = b;
    start_mul = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        a_in = {8{$urandom}};
        b_in = {8{$urandom}};
      end
      if (drop_mid && lat == 10) start_mul = 1'b0;
    end while (!finish_mul && lat < BOUND);
    z = z_out;
  endtask

  task automatic release_big();
    @(negedge clk);
    start_mul = 1'b0;
    @(negedge clk);
  endtask

  task automatic mul_small(input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] z, output int lat);
    @(negedge clk);
    s_a = a;
    s_b = b;
    s_start = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        s_a = 16'($urandom);
        s_b = 16'($urandom);
      end
    end while (!s_finish && lat < BOUND);
    z = s_z;
    @(negedge clk);
    s_start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [255:0] z, a, b, m_div, u_div, inv_u, prev_z;
    logic [15:0]  sz, sa, sb;
    int           lat, pulses;

    // Reset state
    #2;
    check("rst_z", z_out, 256'd0);
    check("rst_finish", 256'(finish_mul), 256'd0);
    check("rst_busy", 256'(busy), 256'd0);
    @(negedge clk);
    rst = 1'b1;

    // 3*5 with start held through and past the finish pulse
    mul_big(256'd3, 256'd5, 1'b0, z, lat);
    check("lat_3x5", 256'(lat), 256'(LAT_BIG));
    check("z_3x5", z, 256'd15);
    check("busy_at_pulse", 256'(busy), 256'd1);
    @(negedge clk);
    check("finish_one_cycle", 256'(finish_mul), 256'd0);
    check("busy_after_pulse", 256'(busy), 256'd0);
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (finish_mul) pulses++;
    end
    check("no_relaunch_pulses", 256'(pulses), 256'd0);
    check("z_held", z_out, 256'd15);
    release_big();

    // Boundary operands; start dropped mid-run for one of them
    mul_big(P_SM2 - 256'd1, P_SM2 - 256'd1, 1'b0, z, lat);
    check("z_pm1_sq", z, 256'd1);
    release_big();
    mul_big(256'd2, P_SM2 - 256'd1, 1'b1, z, lat);
    check("z_2_pm1", z, P_SM2 - 256'd2);
    check("lat_dropped_start", 256'(lat), 256'(LAT_BIG));
    release_big();
    mul_big(256'd0, P_SM2 - 256'd1, 1'b0, z, lat);
    check("z_0_pm1", z, 256'd0);
    release_big();

    // Round trip: divider quotient M = m / u mod P, re-multiplied by u gives m back
    u_div = 256'h8979de91648bbfab51f06344b4777f04904fbca27e8334a58a913060f32f88f;
    m_div = 256'h1a215adce2c34c0ebe9271a59d74c6c4c5bc9a4fd997208a7127cfa9abf4790c;
    inv_u = ref_powmod(u_div, P_SM2 - 256'd2, P_SM2);
    b = ref_mulmod(m_div, inv_u, P_SM2);
    mul_big(u_div, b, 1'b0, z, lat);
    check("z_roundtrip", z, 256'h1a215adce2c34c0ebe9271a59d74c6c4c5bc9a4fd997208a7127cfa9abf4790c);
    release_big();

    // Random SM2-width pairs, relaunch with new operands after each release
    for (int i = 0; i < 16; i++) begin
      a = rand_below_p();
      b = rand_below_p();
      mul_big(a, b, 1'b0, z, lat);
      check($sformatf("z_rand_big_%0d", i), z, ref_mulmod(a, b, P_SM2));
      check($sformatf("lat_rand_big_%0d", i), 256'(lat), 256'(LAT_BIG));
      release_big();
    end

    // Reset asserted asynchronously about 100 cycles into a run
    prev_z = z_out;
    check("pre_reset_result_nonzero", 256'(prev_z != 256'd0), 256'd1);
    @(negedge clk);
    a_in = P_SM2 - 256'd1;
    b_in = P_SM2 - 256'd3;
    start_mul = 1'b1;
    repeat (100) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midrun_rst_z", z_out, 256'd0);
    check("midrun_rst_finish", 256'(finish_mul), 256'd0);
    check("midrun_rst_busy", 256'(busy), 256'd0);
    start_mul = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    mul_big(256'd7, 256'd9, 1'b0, z, lat);
    check("z_after_rst", z, 256'd63);
    check("lat_after_rst", 256'(lat), 256'(LAT_BIG));
    release_big();

    // Long random run on the 16-bit instance
    for (int i = 0; i < 1000; i++) begin
      sa = 16'($urandom_range(0, 65520));
      sb = 16'($urandom_range(0, 65520));
      mul_small(sa, sb, sz, lat);
      check($sformatf("z_rand_small_%0d", i), 256'(sz), ref_mulmod(256'(sa), 256'(sb), 256'(P_S)));
      if (i == 0) check("lat_small", 256'(lat), 256'(LAT_SMALL));
    end

    // Out-of-range operands: result undefined, latency must be unchanged
    mul_small(16'hFFFF, 16'hFFFF, sz, lat);
    check("lat_small_out_of_range", 256'(lat), 256'(LAT_SMALL));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
